// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
//   alu_op_e   : 4-bit ALU operation codes driven by decode
//   md_state_e : iterative multiply/divide controller states
//   is_muldiv  : true for the codes that run on the iterative unit
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MULU  = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_MFHI  = 4'd14,
    ALU_PASSA = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == ALU_MULU) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/exec_stage_mc_if.sv
// Decode-side and memory-side signals of the execute stage.
//   master : the surrounding pipeline (decode drives d_*/in_valid, memory drives out_ready)
//   slave  : the execute stage itself
interface exec_stage_mc_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              d_reg_dst, d_alu_src, d_mem_to_reg, d_reg_write, d_mem_wr;
  logic              d_branch, d_jump, d_jal, d_jar, d_loadext;
  logic [3:0]        d_alu_ctrl;
  logic [1:0]        d_dsize, d_fpoint;
  logic [WIDTH-1:0]  d_imm, d_bus_a, d_bus_b, d_next_addr;
  logic [REG_AW-1:0] d_rd, d_rt;

  logic              out_valid;
  logic              out_ready;
  logic              mem_wr, branch, mem_to_reg, reg_wr, jump, jal, jar, loadext;
  logic [1:0]        dsize, fpoint;
  logic              zero;
  logic [WIDTH-1:0]  alu_out, bus_b, branch_target;
  logic [REG_AW-1:0] rw;
  logic              busy;

  modport master (
    output flush, in_valid, d_reg_dst, d_alu_src, d_mem_to_reg, d_reg_write, d_mem_wr,
           d_branch, d_jump, d_jal, d_jar, d_loadext, d_alu_ctrl, d_dsize, d_fpoint,
           d_imm, d_bus_a, d_bus_b, d_next_addr, d_rd, d_rt, out_ready,
    input  in_ready, out_valid, mem_wr, branch, mem_to_reg, reg_wr, jump, jal, jar,
           loadext, dsize, fpoint, zero, alu_out, bus_b, branch_target, rw, busy
  );

  modport slave (
    input  flush, in_valid, d_reg_dst, d_alu_src, d_mem_to_reg, d_reg_write, d_mem_wr,
           d_branch, d_jump, d_jal, d_jar, d_loadext, d_alu_ctrl, d_dsize, d_fpoint,
           d_imm, d_bus_a, d_bus_b, d_next_addr, d_rd, d_rt, out_ready,
    output in_ready, out_valid, mem_wr, branch, mem_to_reg, reg_wr, jump, jal, jar,
           loadext, dsize, fpoint, zero, alu_out, bus_b, branch_target, rw, busy
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
//   start/op : begin an operation (op=0 MULU, op=1 DIVU) with operands a, b
//   ack      : result consumed, leave DONE
//   flush    : abandon any operation, return to IDLE
//   done     : result valid on lo (product low / quotient), hi (product high / remainder)
//   busy     : controller not IDLE
// CYCLES must equal WIDTH for the shift sequence to cover every operand bit.
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             ack,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(CYCLES + 1);

  md_state_e        state, state_next;
  logic [CW-1:0]    cnt;
  logic             div_q;
  // acc: running high product / partial remainder; q: multiplier / dividend-quotient.
  logic [WIDTH-1:0] acc, q, m;
  logic [WIDTH-1:0] acc_step, q_step;
  logic [WIDTH:0]   sum, r_sh;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (cnt == CW'(1)) state_next = MD_DONE;
      MD_DONE: if (ack) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  // One iteration: shift-add for multiply, compare/subtract-and-shift for divide.
  // A zero divisor always "fits", yielding an all-ones quotient and remainder = dividend.
  always_comb begin
    acc_step = '0;
    q_step   = '0;
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    r_sh     = {acc, q[WIDTH-1]};
    if (div_q) begin
      if (r_sh >= {1'b0, m}) begin
        acc_step = WIDTH'(r_sh - {1'b0, m});
        q_step   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = r_sh[WIDTH-1:0];
        q_step   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = sum[WIDTH:1];
      q_step   = {sum[0], q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  // NOTE: the datapath registers are reset as well, so lo/hi never present X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= 1'b0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (state == MD_IDLE && start) begin
      cnt   <= CW'(CYCLES);
      div_q <= op;
      acc   <= '0;
      q     <= a;
      m     <= b;
    end else if (state == MD_BUSY) begin
      cnt <= cnt - CW'(1);
      acc <= acc_step;
      q   <= q_step;
    end
  end

  assign done = (state == MD_DONE);
  assign busy = (state != MD_IDLE);
  assign lo   = q;
  assign hi   = acc;

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU, branch target / destination generation,
// iterative MULU/DIVU with a HI register, and the EX/MEM pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode inputs (d_*, in_valid/in_ready), flush, registered
//                EX/MEM outputs (out_valid/out_ready handshake), busy
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_AW    = 5,
  parameter int MD_CYCLES = WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_stage_mc_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic              mem_wr, branch, mem_to_reg, reg_wr, jump, jal, jar, loadext;
    logic [1:0]        dsize, fpoint;
    logic [WIDTH-1:0]  bus_b, branch_target;
    logic [REG_AW-1:0] rw;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
  } out_t;

  out_t             out_q;
  ctrl_t            pend_q;   // controls of the op currently in the mul/div unit
  ctrl_t            ctrl_in;
  logic             out_valid_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] op_b, alu_res;
  logic             slot_free, accept, is_md, md_start, md_ack;
  logic             md_done, md_busy;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rst_n && !md_busy && slot_free && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_md        = is_muldiv(bus.d_alu_ctrl);
  assign md_start     = accept && is_md;
  // Completion waits for a free output slot; a flush in the same cycle wins.
  assign md_ack       = md_done && slot_free && !bus.flush;

  assign op_b = bus.d_alu_src ? bus.d_imm : bus.d_bus_b;

  always_comb begin
    ctrl_in               = '0;
    ctrl_in.mem_wr        = bus.d_mem_wr;
    ctrl_in.branch        = bus.d_branch;
    ctrl_in.mem_to_reg    = bus.d_mem_to_reg;
    ctrl_in.reg_wr        = bus.d_reg_write;
    ctrl_in.jump          = bus.d_jump;
    ctrl_in.jal           = bus.d_jal;
    ctrl_in.jar           = bus.d_jar;
    ctrl_in.loadext       = bus.d_loadext;
    ctrl_in.dsize         = bus.d_dsize;
    ctrl_in.fpoint        = bus.d_fpoint;
    ctrl_in.bus_b         = bus.d_bus_b;
    ctrl_in.branch_target = bus.d_next_addr + (bus.d_imm << 2);
    ctrl_in.rw            = bus.d_jal ? '1 : (bus.d_reg_dst ? bus.d_rd : bus.d_rt);
  end

  always_comb begin
    alu_res = '0;
    case (bus.d_alu_ctrl)
      ALU_ADD:   alu_res = bus.d_bus_a + op_b;
      ALU_SUB:   alu_res = bus.d_bus_a - op_b;
      ALU_AND:   alu_res = bus.d_bus_a & op_b;
      ALU_OR:    alu_res = bus.d_bus_a | op_b;
      ALU_XOR:   alu_res = bus.d_bus_a ^ op_b;
      ALU_NOR:   alu_res = ~(bus.d_bus_a | op_b);
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.d_bus_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, bus.d_bus_a < op_b};
      ALU_SLL:   alu_res = bus.d_bus_a << op_b[SHW-1:0];
      ALU_SRL:   alu_res = bus.d_bus_a >> op_b[SHW-1:0];
      ALU_SRA:   alu_res = WIDTH'($signed(bus.d_bus_a) >>> op_b[SHW-1:0]);
      ALU_LUI:   alu_res = op_b << (WIDTH / 2);
      ALU_MFHI:  alu_res = hi_q;
      ALU_PASSA: alu_res = bus.d_bus_a;
      default:   alu_res = '0;   // MULU/DIVU results come from the iterative unit
    endcase
  end

  iter_muldiv #(
    .WIDTH  (WIDTH),
    .CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (bus.d_alu_ctrl == ALU_DIVU),
    .ack   (md_ack),
    .flush (bus.flush),
    .a     (bus.d_bus_a),
    .b     (op_b),
    .done  (md_done),
    .busy  (md_busy),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  // EX/MEM register: drain on out_ready, then a completion or a single-cycle
  // accept may reload it in the same cycle. Accept and completion are exclusive
  // because accept requires the mul/div unit to be idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pend_q      <= '0;
      hi_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (md_ack) begin
        out_valid_q <= 1'b1;
        out_q       <= '{ctrl: pend_q, alu_out: md_lo, zero: (md_lo == '0)};
        hi_q        <= md_hi;
      end else if (accept && !is_md) begin
        out_valid_q <= 1'b1;
        out_q       <= '{ctrl: ctrl_in, alu_out: alu_res, zero: (alu_res == '0)};
      end
      if (md_start) pend_q <= ctrl_in;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.mem_wr        = out_q.ctrl.mem_wr;
  assign bus.branch        = out_q.ctrl.branch;
  assign bus.mem_to_reg    = out_q.ctrl.mem_to_reg;
  assign bus.reg_wr        = out_q.ctrl.reg_wr;
  assign bus.jump          = out_q.ctrl.jump;
  assign bus.jal           = out_q.ctrl.jal;
  assign bus.jar           = out_q.ctrl.jar;
  assign bus.loadext       = out_q.ctrl.loadext;
  assign bus.dsize         = out_q.ctrl.dsize;
  assign bus.fpoint        = out_q.ctrl.fpoint;
  assign bus.bus_b         = out_q.ctrl.bus_b;
  assign bus.branch_target = out_q.ctrl.branch_target;
  assign bus.rw            = out_q.ctrl.rw;
  assign bus.alu_out       = out_q.alu_out;
  assign bus.zero          = out_q.zero;
  assign bus.busy          = md_busy;

endmodule

// File: tb/tb_exec_stage_mc.sv
module tb_exec_stage_mc;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exec_stage_mc_if #(.WIDTH(32), .REG_AW(5)) bus ();

  exec_stage_mc #(.WIDTH(32), .REG_AW(5), .MD_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ALU vectors, issued back to back; odd entries route B through the immediate.
  logic [3:0]  v_op  [13] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
                              ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASSA};
  logic [31:0] v_a   [13] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555,
                              32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                              32'h80000000, 32'h0, 32'hDEADBEEF};
  logic [31:0] v_b   [13] = '{32'd1, 32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000,
                              32'h0, 32'd1, 32'd1, 32'h3F, 32'd4, 32'd4, 32'hABCD1234, 32'h0};
  logic [31:0] v_exp [13] = '{32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'h55555555,
                              32'hFFFFFFFF, 32'd1, 32'd0, 32'h80000000, 32'h08000000,
                              32'hF8000000, 32'h12340000, 32'hDEADBEEF};

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid     = 1'b1;
    bus.d_alu_ctrl   = op;
    bus.d_bus_a      = a;
    bus.d_bus_b      = b;
    bus.d_imm        = '0;
    bus.d_alu_src    = 1'b0;
    bus.d_reg_dst    = 1'b1;
    bus.d_rd         = '0;
    bus.d_rt         = '0;
    bus.d_reg_write  = 1'b1;
    bus.d_mem_to_reg = 1'b0;
    bus.d_mem_wr     = 1'b0;
    bus.d_branch     = 1'b0;
    bus.d_jump       = 1'b0;
    bus.d_jal        = 1'b0;
    bus.d_jar        = 1'b0;
    bus.d_loadext    = 1'b0;
    bus.d_dsize      = '0;
    bus.d_fpoint     = '0;
    bus.d_next_addr  = '0;
  endtask

  // Issue one single-cycle op at a negedge and sample its result one cycle later.
  task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic v);
    drive(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    res = bus.alu_out;
    v   = bus.out_valid;
  endtask

  // Issue a MULU/DIVU and wait (bounded) for its result; bad counts cycles where
  // the stage looked idle or ready while the unit was still working.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc, output int bad);
    drive(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    bad = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (!bus.busy || bus.in_ready) bad++;
      @(negedge clk);
      cyc++;
    end
    res = bus.alu_out;
  endtask

  task automatic test_reset();
    drive(ALU_ADD, 32'd0, 32'd0);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.alu_out !== 32'h0 || bus.rw !== 5'd0 || bus.zero !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: alu_out=%h rw=%0d zero=%b busy=%b expected all 0", bus.alu_out, bus.rw, bus.zero, bus.busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_add();
    @(negedge clk);
    drive(ALU_ADD, 32'd5, 32'd7);
    bus.d_rd = 5'd3;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.alu_out !== 32'd12) begin errors++; $display("FAIL add_alu_out: got %h expected %h", bus.alu_out, 32'd12); end
    checks++; if (bus.zero !== 1'b0 || bus.rw !== 5'd3 || bus.bus_b !== 32'd7)
      begin errors++; $display("FAIL add_fields: zero=%b rw=%0d bus_b=%0d expected 0/3/7", bus.zero, bus.rw, bus.bus_b); end
    // Link write: jal forces rw to 31; passthrough fields follow.
    drive(ALU_ADD, 32'd1, 32'd1);
    bus.d_jal = 1'b1; bus.d_rd = 5'd4; bus.d_dsize = 2'b10; bus.d_fpoint = 2'b01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.rw !== 5'd31 || bus.jal !== 1'b1 || bus.dsize !== 2'b10 || bus.fpoint !== 2'b01)
      begin errors++; $display("FAIL jal_fields: rw=%0d jal=%b dsize=%b fpoint=%b expected 31/1/10/01", bus.rw, bus.jal, bus.dsize, bus.fpoint); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_sub_branch();
    drive(ALU_SUB, 32'h00620820, 32'h00620820);
    bus.d_branch = 1'b1; bus.d_next_addr = 32'h00620824; bus.d_imm = 32'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.zero !== 1'b1 || bus.alu_out !== 32'h0 || bus.branch !== 1'b1)
      begin errors++; $display("FAIL sub_zero: zero=%b alu_out=%h branch=%b expected 1/0/1", bus.zero, bus.alu_out, bus.branch); end
    checks++; if (bus.branch_target !== 32'h00620834) begin errors++; $display("FAIL branch_target: got %h expected %h", bus.branch_target, 32'h00620834); end
    drive(ALU_ADD, 32'd0, 32'd0);
    bus.d_next_addr = 32'hFFFFFFFC; bus.d_imm = 32'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.branch_target !== 32'h00000004) begin errors++; $display("FAIL branch_target_wrap: got %h expected %h", bus.branch_target, 32'h4); end
  endtask

  task automatic test_alu_vectors();
    for (int i = 0; i < 13; i++) begin
      drive(v_op[i], v_a[i], (i % 2 == 1) ? 32'h5A5A5A5A : v_b[i]);
      if (i % 2 == 1) begin bus.d_alu_src = 1'b1; bus.d_imm = v_b[i]; end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.alu_out !== v_exp[i] || bus.zero !== (v_exp[i] == 32'h0)) begin
        errors++;
        $display("FAIL alu_vec_%0d: valid=%b alu_out=%h zero=%b expected 1/%h/%b", i, bus.out_valid, bus.alu_out, bus.zero, v_exp[i], v_exp[i] == 32'h0);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mulu();
    logic [31:0] res;
    logic        v;
    int          cyc, bad;
    run_md(ALU_MULU, 32'hFFFFFFFF, 32'd2, res, cyc, bad);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mulu_latency: got %0d cycles expected 33", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mulu_busy_stall: %0d cycles not busy/stalled, expected 0", bad); end
    checks++; if (res !== 32'hFFFFFFFE || bus.zero !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL mulu_result: alu_out=%h zero=%b busy=%b expected fffffffe/0/0", res, bus.zero, bus.busy); end
    run_single(ALU_MFHI, 32'd0, 32'd0, res, v);
    checks++; if (v !== 1'b1 || res !== 32'd1) begin errors++; $display("FAIL mulu_mfhi: valid=%b alu_out=%h expected 1/%h", v, res, 32'd1); end
    @(negedge clk);
  endtask

  task automatic test_divu();
    logic [31:0] res;
    logic        v;
    int          cyc, bad;
    run_md(ALU_DIVU, 32'd100, 32'd0, res, cyc, bad);
    checks++; if (res !== 32'hFFFFFFFF || cyc !== 33) begin errors++; $display("FAIL divu_zero_q: alu_out=%h cycles=%0d expected ffffffff/33", res, cyc); end
    run_single(ALU_MFHI, 32'd0, 32'd0, res, v);
    checks++; if (v !== 1'b1 || res !== 32'd100) begin errors++; $display("FAIL divu_zero_rem: valid=%b alu_out=%0d expected 1/100", v, res); end
    @(negedge clk);
    run_md(ALU_DIVU, 32'd100, 32'd7, res, cyc, bad);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_q: got %0d expected 14", res); end
    run_single(ALU_MFHI, 32'd0, 32'd0, res, v);
    checks++; if (v !== 1'b1 || res !== 32'd2) begin errors++; $display("FAIL divu_rem: valid=%b alu_out=%0d expected 1/2", v, res); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1);
    bus.d_rd = 5'd1;
    @(negedge clk);
    drive(ALU_ADD, 32'd3, 32'd4);
    bus.d_rd = 5'd2;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_out !== 32'd2 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_first: valid=%b alu_out=%0d in_ready=%b expected 1/2/0", bus.out_valid, bus.alu_out, bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_out !== 32'd2 || bus.rw !== 5'd1 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_hold: valid=%b alu_out=%0d rw=%0d in_ready=%b expected 1/2/1/0", bus.out_valid, bus.alu_out, bus.rw, bus.in_ready); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_out !== 32'd7 || bus.rw !== 5'd2)
      begin errors++; $display("FAIL bp_second: valid=%b alu_out=%0d rw=%0d expected 1/7/2", bus.out_valid, bus.alu_out, bus.rw); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic        v;
    drive(ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    drive(ALU_ADD, 32'd9, 32'd9);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_kill: busy=%b out_valid=%b expected 0/0", bus.busy, bus.out_valid); end
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ignores_input: got %b expected 0", bus.out_valid); end
    run_single(ALU_MFHI, 32'd0, 32'd0, res, v);
    checks++; if (v !== 1'b1 || res !== 32'd2) begin errors++; $display("FAIL flush_hi_kept: valid=%b alu_out=%0d expected 1/2", v, res); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic        v;
    run_single(ALU_PASSA, 32'h12345678, 32'd0, res, v);
    @(negedge clk);
    drive(ALU_MULU, 32'd3, 32'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.alu_out !== 32'h0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL async_reset: alu_out=%h valid=%b busy=%b in_ready=%b expected all 0", bus.alu_out, bus.out_valid, bus.busy, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_single(ALU_MFHI, 32'd0, 32'd0, res, v);
    checks++; if (v !== 1'b1 || res !== 32'd0) begin errors++; $display("FAIL async_reset_hi: valid=%b alu_out=%0d expected 1/0", v, res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_alu_vectors();
    test_mulu();
    test_divu();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute stage for the 5-stage pipeline: single-cycle ALU ops, branch-target/destination generation, and an iterative multiply/divide unit with a HI register. Sits between decode and memory stages. Owns the EX/MEM pipeline register and uses valid/ready handshakes so multi-cycle ops and downstream back-pressure stall decode.

Parameters:
WIDTH, 32, datapath width (bus, immediate, address)
REG_AW, 5, register-address width; link register = all ones (31)
MD_CYCLES, WIDTH, iterations for MUL/DIVU (1 bit per cycle; must equal WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight op and output slot
in_valid  in  1  decode presents an op
in_ready  out  1  stage can accept this cycle
d_reg_dst, d_alu_src, d_mem_to_reg, d_reg_write, d_mem_wr, d_branch, d_jump, d_jal, d_jar, d_loadext  in  1 each  decoded controls
d_alu_ctrl  in  4  op code (pkg)
d_dsize, d_fpoint  in  2 each  passthrough
d_imm, d_bus_a, d_bus_b, d_next_addr  in  WIDTH each  operands/PC+4
d_rd, d_rt  in  REG_AW each  destination candidates
out_valid  out  1  EX/MEM register holds a valid op
out_ready  in  1  memory stage accepts
mem_wr, branch, mem_to_reg, reg_wr, jump, jal, jar, loadext  out  1 each  registered controls
dsize, fpoint  out  2 each  registered passthrough
zero  out  1  alu_out == 0
alu_out, bus_b, branch_target  out  WIDTH each  results
rw  out  REG_AW  write register
busy  out  1  mul/div FSM not IDLE

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM IDLE, hi = 0, counter = 0; in_ready = 0 during reset, 1 after release.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
- Operand B = d_alu_src ? d_imm : d_bus_b. rw = d_jal ? all-ones : (d_reg_dst ? d_rd : d_rt).
- branch_target = d_next_addr + (d_imm << 2), WIDTH bits, wraps.
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift amount B[log2 WIDTH-1:0]), 11 LUI (B << WIDTH/2), 12 MULU, 13 DIVU, 14 MFHI, 15 passes A. Add/sub wrap, no overflow trap.
- Single-cycle op: accepted at edge N -> out_valid=1 with results after edge N (latency 1).
- MULU/DIVU: on accept, latch operands, state IDLE->BUSY, counter=MD_CYCLES. Each cycle one shift-add / restoring-subtract step. Counter reaching 0 -> DONE. DONE->IDLE when output slot free (!out_valid || out_ready): alu_out = low product / quotient, hi = high product / remainder, out_valid=1. Total latency MD_CYCLES+1 cycles minimum.
- DIVU by zero: quotient all ones, remainder = dividend.
- MFHI reads hi as updated by the most recent completed MULU/DIVU; back-to-back MULU then MFHI returns the new hi (no hazard).
- Output register holds while out_valid && !out_ready; new op loads when out_ready or slot empty; simultaneous drain and load allowed.
- flush: next edge out_valid=0, BUSY/DONE -> IDLE, hi unchanged, any in_valid in that cycle ignored. flush beats accept and completion.
- zero computed on final alu_out value (also for MULU/DIVU).

Decomposition:
- Package exec_pkg: alu_ctrl codes as localparams/enum, MD state enum (IDLE, BUSY, DONE).
- Sub-module iter_muldiv (WIDTH): start, op, a, b, flush -> done, lo, hi; contains counter and shift registers. ALU and pipeline register stay in top.

Test Plan:
- Reset release, ADD a=5, b=7, rd=3, reg_dst=1, out_ready=1 -> next cycle out_valid=1, alu_out=12, zero=0, rw=3.
- SUB a=b=0x00620820, alu_src=0; then branch with d_next_addr=0x00620824, imm=4 -> zero=1; branch_target=0x00620834.
- MULU a=0xFFFFFFFF, b=2 -> busy for 32 cycles, in_ready=0; then alu_out=0xFFFFFFFE; following MFHI -> alu_out=1.
- DIVU a=100, b=0 -> alu_out=0xFFFFFFFF; MFHI -> 100. DIVU 100/7 -> 14, hi 2.
- Back-pressure: out_ready=0 with two ADDs queued -> first held stable, in_ready=0; out_ready=1 -> second loads next cycle, no loss/duplication.
- flush asserted mid-MULU (cycle 10) -> busy=0 and out_valid=0 next cycle, hi unchanged; async rst_n pulse mid-op -> all outputs 0 immediately.
